imm_encoder: RTL

Pipelined immediate encoder for the core's instruction-generation path (self-test ROM builder and debug instruction injector). It performs the inverse of the core's immediate decoder: it takes a 32-bit immediate value, an immediate-format select and an instruction template, and scatters the immediate bits into the format-specific bit positions. Each result carries range and alignment error flags. A valid/ready handshake sits on both sides, with a two-stage registered pipeline and a saturating error counter.

---
 rtl/imm_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: pipelined immediate encoder, the inverse of the core's
// immediate decoder. Scatters a 32-bit immediate into the I/B/S/U/J field
// positions of an instruction template and flags immediates that do not
// fit the format (range_err_o) or are misaligned branch/jump offsets
// (align_err_o).
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   in_valid_i / in_ready_o  input handshake
//   imm_src_i                format: 000 I, 001 B, 010 S, 011 U, 100 J
//   imm_i, instr_i           immediate value and instruction template
//   out_valid_o / out_ready_i output handshake
//   instr_o                  encoded instruction
//   range_err_o, align_err_o advisory error flags
//   err_count_o              saturating count of delivered errored results
//
// Pipeline: stage 1 registers the request, the encoder sits between the
// stages, stage 2 registers the result. Each stage advances when it is
// empty or its consumer takes data, so two transactions can be parked
// under backpressure. Only DATA_WIDTH = 32 is meaningful; field positions
// are fixed by the instruction formats.
module imm_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            imm_src_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  range_err_o,
  output logic                  align_err_o,
  output logic [15:0]           err_count_o
);

  localparam int STAGES = 2;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_B = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  typedef struct packed {
    logic [2:0]            src;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] instr;
  } req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic                  range_err;
    logic                  align_err;
  } rsp_t;

  logic [STAGES:1] vld_pipe;
  req_t            s1_q;
  rsp_t            s2_q;
  rsp_t            enc;
  logic            s1_adv;
  logic            s2_adv;
  logic [15:0]     err_cnt_q;

  // Handshake: a stage moves when empty or when its consumer drains it.
  assign s2_adv     = !vld_pipe[2] || out_ready_i;
  assign s1_adv     = !vld_pipe[1] || s2_adv;
  assign in_ready_o = s1_adv;

  // Sign-uniformity of the bits above each format's top immediate bit:
  // the value is representable iff they are all copies of the sign bit.
  logic [31:0] imm;
  logic        fit11, fit12, fit19, fit20;

  assign imm   = s1_q.imm;
  assign fit11 = (&imm[31:11]) || !(|imm[31:11]);
  assign fit12 = (&imm[31:12]) || !(|imm[31:12]);
  assign fit19 = (&imm[31:19]) || !(|imm[31:19]);
  assign fit20 = (&imm[31:20]) || !(|imm[31:20]);

  // Out-of-range immediates are still encoded with their low bits.
  always_comb begin
    enc           = '0;
    enc.instr     = s1_q.instr;
    case (s1_q.src)
      FMT_I: begin
        enc.instr[31:20] = imm[11:0];
        enc.range_err    = !fit11;
      end
      FMT_B: begin
        enc.instr[31]    = imm[12];
        enc.instr[30:25] = imm[10:5];
        enc.instr[11:8]  = imm[4:1];
        enc.instr[7]     = imm[11];
        enc.range_err    = !fit12;
        enc.align_err    = imm[0];
      end
      FMT_S: begin
        enc.instr[31:25] = imm[11:5];
        enc.instr[11:7]  = imm[4:0];
        enc.range_err    = !fit11;
      end
      FMT_U: begin
        // Unshifted 20-bit value, as the decoder's U output presents it.
        enc.instr[31:12] = imm[19:0];
        enc.range_err    = !fit19;
      end
      FMT_J: begin
        enc.instr[31]    = imm[20];
        enc.instr[30:21] = imm[10:1];
        enc.instr[20]    = imm[11];
        enc.instr[19:12] = imm[19:12];
        enc.range_err    = !fit20;
        enc.align_err    = imm[0];
      end
      default: begin
        // Unknown format: template passes through untouched.
        enc.range_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      err_cnt_q <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid_i;
        if (in_valid_i) s1_q <= '{src: imm_src_i, imm: imm_i, instr: instr_i};
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= enc;
      end
      if (vld_pipe[2] && out_ready_i && (s2_q.range_err || s2_q.align_err)
          && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign out_valid_o = vld_pipe[2];
  assign instr_o     = s2_q.instr;
  assign range_err_o = s2_q.range_err;
  assign align_err_o = s2_q.align_err;
  assign err_count_o = err_cnt_q;

endmodule
